alu_seq_param: RTL and testbench
================================

ALU_SEQ_PARAM -- requirements
Module: alu_seq_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, operand/result width (legal 8..256, power of two).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 opcode  input  4  operation select, encoding in REQ-014.
REQ-008 input1, input2  input  WIDTH each  operands.
REQ-009 shiftValue  input  SHW  shift/rotate amount.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH; carryFlag, zeroFlag, overFlowFlag, signFlag, illegalFlag  output  1 each.

Function
REQ-013 Handshake: request accepted when in_valid && in_ready; result consumed when out_valid && out_ready; operands, opcode, shiftValue captured at accept.
REQ-014 Opcodes: 0 SRL, 1 MIN (unsigned), 2 MUL, 3 AND, 4 SGE, 5 XNOR, 6 ROR, 7 OR, 8 SLL, 9 NAND, 10 XOR, 11 ROL, 12 SLT, 13 SRA; 14/15 illegal.
REQ-015 SGE/SLT: signed two's-complement compare of input1 vs input2; result = 1 (zero-extended) if true, else 0.
REQ-016 Rotates SHALL be modulo WIDTH; shiftValue 0 returns input1 unchanged for all shift/rotate ops.
REQ-017 MUL: unsigned, low WIDTH bits of 2*WIDTH product in result; computed iteratively, one multiplier bit per cycle (shift-add), no combinational WIDTH x WIDTH multiplier.
REQ-018 States: IDLE, MUL_BUSY, HOLD. IDLE->HOLD on accept of non-MUL op; IDLE->MUL_BUSY on accept of MUL; MUL_BUSY->HOLD after WIDTH iteration cycles; HOLD->IDLE on out_valid && out_ready unless a new request is accepted the same cycle.
REQ-019 in_ready = (state==IDLE) || (state==HOLD && out_ready); back-to-back single-cycle ops SHALL sustain one result per cycle.
REQ-020 Latency: non-MUL out_valid on cycle after accept; MUL out_valid WIDTH+1 cycles after accept.
REQ-021 out_valid stays high and result/flags stay stable until consumed (out_ready back-pressure).
REQ-022 zeroFlag = (result==0); signFlag = result[WIDTH-1] for every op.
REQ-023 carryFlag: SLL = last bit shifted out (input1[WIDTH-shiftValue]); SRL/SRA = input1[shiftValue-1]; MUL = upper product half nonzero; 0 when shiftValue==0 and for all other ops.
REQ-024 overFlowFlag: MUL = upper product half nonzero; 0 for all other ops.
REQ-025 Illegal opcode: result 0, illegalFlag 1, zeroFlag 1, other flags 0, latency as non-MUL op; illegalFlag 0 for legal ops.
REQ-026 in_valid while in_ready low SHALL be ignored (no capture, no side effect).

Reset
REQ-027 On rst assertion, immediately: state IDLE, out_valid 0, result 0, all flags 0, multiplier datapath cleared; in_ready 1 from first clock after rst deassertion.
REQ-028 rst during MUL_BUSY or HOLD SHALL abort the operation; no result is later emitted for it.

Verification
REQ-029 WIDTH=8: accept MUL 8'h10*8'h11 with out_ready=1 -> out_valid exactly 9 cycles later, result 8'h10, carryFlag 1, overFlowFlag 1, zeroFlag 0.
REQ-030 WIDTH=8: SLT 8'hFF vs 8'h01 -> result 8'h01; SGE same operands -> 8'h00, zeroFlag 1.
REQ-031 WIDTH=8: ROL 8'b1000_0001 by 1 -> 8'b0000_0011; SLL 8'h81 by 1 -> 8'h02, carryFlag 1; SRA 8'h80 by 3 -> 8'hF0, signFlag 1.
REQ-032 WIDTH=128: stream 4 XOR ops back-to-back with out_ready=1 -> 4 consecutive out_valid cycles, in_ready never low; then hold out_ready=0 -> result stable, in_ready 0 until released.
REQ-033 opcode 15 -> result 0, illegalFlag 1, zeroFlag 1; then assert rst mid-MUL (cycle 3 of 128) -> out_valid never asserted for that MUL, next ADD-free op (AND) completes normally in 1 cycle.

Source files
------------

// File: rtl/alu_seq_param.sv
// Sequential ALU with a valid/ready handshake on both sides.
// Single-cycle ops go straight to HOLD and are registered at accept.
// MUL runs a shift-add loop, one multiplier bit per cycle.
// HOLD keeps the result stable until it is consumed.
module alu_seq_param #(
  parameter int WIDTH = 128,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shiftValue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             overFlowFlag,
  output logic             signFlag,
  output logic             illegalFlag
);

  localparam logic [3:0] OP_SRL  = 4'd0,  OP_MIN  = 4'd1,  OP_MUL  = 4'd2,  OP_AND = 4'd3;
  localparam logic [3:0] OP_SGE  = 4'd4,  OP_XNOR = 4'd5,  OP_ROR  = 4'd6,  OP_OR  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8,  OP_NAND = 4'd9,  OP_XOR  = 4'd10, OP_ROL = 4'd11;
  localparam logic [3:0] OP_SLT  = 4'd12, OP_SRA  = 4'd13;

  typedef enum logic [1:0] {IDLE, MUL_BUSY, HOLD} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d;
  logic               sign_q, sign_d, ill_q, ill_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  logic               accept;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c, alu_il;
  logic               sh_nz, s_lt, s_ge;
  logic [SHW-1:0]     sh_inv;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);

  assign result       = result_q;
  assign carryFlag    = carry_q;
  assign zeroFlag     = zero_q;
  assign overFlowFlag = ovf_q;
  assign signFlag     = sign_q;
  assign illegalFlag  = ill_q;

  // WIDTH - shiftValue, truncated: only meaningful (1..WIDTH-1) when shiftValue != 0
  assign sh_nz  = (shiftValue != '0);
  assign sh_inv = SHW'(WIDTH - int'(shiftValue));
  assign s_lt   = $signed(input1) <  $signed(input2);
  assign s_ge   = $signed(input1) >= $signed(input2);

  // one shift-add step: add multiplicand into upper half if LSB set, shift right
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  // single-cycle ALU result and carry from the live inputs (registered at accept)
  always_comb begin
    alu_r  = '0;
    alu_c  = 1'b0;
    alu_il = 1'b0;
    case (opcode)
      OP_SRL:  begin alu_r = input1 >> shiftValue; alu_c = sh_nz & input1[shiftValue - SHW'(1)]; end
      OP_MIN:  alu_r = (input1 < input2) ? input1 : input2;
      OP_MUL:  alu_r = '0;
      OP_AND:  alu_r = input1 & input2;
      OP_SGE:  alu_r = {{(WIDTH-1){1'b0}}, s_ge};
      OP_XNOR: alu_r = ~(input1 ^ input2);
      // shifting by WIDTH yields zero, so shiftValue==0 leaves input1 intact
      OP_ROR:  alu_r = (input1 >> shiftValue) | (input1 << (WIDTH - int'(shiftValue)));
      OP_OR:   alu_r = input1 | input2;
      OP_SLL:  begin alu_r = input1 << shiftValue; alu_c = sh_nz & input1[sh_inv]; end
      OP_NAND: alu_r = ~(input1 & input2);
      OP_XOR:  alu_r = input1 ^ input2;
      OP_ROL:  alu_r = (input1 << shiftValue) | (input1 >> (WIDTH - int'(shiftValue)));
      OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, s_lt};
      OP_SRA:  begin alu_r = $signed(input1) >>> shiftValue; alu_c = sh_nz & input1[shiftValue - SHW'(1)]; end
      default: alu_il = 1'b1;
    endcase
  end

  // next-state: multiply iteration, consume, and accept (accept overrides consume)
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    sign_d   = sign_q;
    ill_d    = ill_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      MUL_BUSY: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_d  = HOLD;
          result_d = mul_next[WIDTH-1:0];
          carry_d  = |mul_next[2*WIDTH-1:WIDTH];
          ovf_d    = |mul_next[2*WIDTH-1:WIDTH];
          zero_d   = (mul_next[WIDTH-1:0] == '0);
          sign_d   = mul_next[WIDTH-1];
          ill_d    = 1'b0;
        end
      end
      HOLD:    if (out_ready) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      if (opcode == OP_MUL) begin
        state_d = MUL_BUSY;
        mcand_d = input1;
        prod_d  = {{WIDTH{1'b0}}, input2};
        cnt_d   = '0;
      end else begin
        state_d  = HOLD;
        result_d = alu_r;
        carry_d  = alu_c;
        ovf_d    = 1'b0;
        zero_d   = (alu_r == '0);
        sign_d   = alu_r[WIDTH-1];
        ill_d    = alu_il;
      end
    end
  end

  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sign_q   <= 1'b0;
      ill_q    <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      sign_q   <= sign_d;
      ill_q    <= ill_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench: two instances (WIDTH=8 and WIDTH=128) with directed vectors.
module tb_alu_seq_param;

  typedef struct {
    string        nm;
    logic [127:0] r;
    logic [4:0]   f;   // {carry, zero, overflow, sign, illegal}
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        rst8, iv8, ir8, ov8, ordy8, c8, z8, v8, s8, il8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, r8;
  logic [2:0]  sh8;
  // WIDTH=128 instance
  logic         rst128, iv128, ir128, ov128, ordy128, c128, z128, v128, s128, il128;
  logic [3:0]   op128;
  logic [127:0] a128, b128, r128;
  logic [6:0]   sh128;

  alu_seq_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .opcode(op8),
    .input1(a8), .input2(b8), .shiftValue(sh8), .out_valid(ov8), .out_ready(ordy8),
    .result(r8), .carryFlag(c8), .zeroFlag(z8), .overFlowFlag(v8), .signFlag(s8),
    .illegalFlag(il8));

  alu_seq_param #(.WIDTH(128)) u128 (
    .clk(clk), .rst(rst128), .in_valid(iv128), .in_ready(ir128), .opcode(op128),
    .input1(a128), .input2(b128), .shiftValue(sh128), .out_valid(ov128), .out_ready(ordy128),
    .result(r128), .carryFlag(c128), .zeroFlag(z128), .overFlowFlag(v128), .signFlag(s128),
    .illegalFlag(il128));

  exp_t q8[$];
  exp_t q128[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   v128_cnt = 0;
  int   ir_low = 0;

  task automatic chk_v(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic chk_out(input exp_t e, input logic [127:0] r, input logic [4:0] f);
    n_cmp++;
    if (r !== e.r || f !== e.f) begin
      n_err++;
      $display("FAIL %s: got result %h flags(c,z,v,s,il) %b expected result %h flags %b",
               e.nm, r, f, e.r, e.f);
    end
  endtask

  // monitors: pop and compare on every consumed result
  always @(negedge clk) begin
    if (!rst8 && ov8 && ordy8) begin
      if (q8.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL w8_unexpected: out_valid with empty scoreboard, got %h expected none", r8);
      end else chk_out(q8.pop_front(), {120'b0, r8}, {c8, z8, v8, s8, il8});
    end
  end

  always @(negedge clk) begin
    if (!rst128 && ov128 && ordy128) begin
      v128_cnt++;
      if (q128.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL w128_unexpected: out_valid with empty scoreboard, got %h expected none", r128);
      end else chk_out(q128.pop_front(), r128, {c128, z128, v128, s128, il128});
    end
  end

  // drive one request, wait (bounded) for in_ready, push expectation, pass the accept edge
  task automatic issue(input int d, input string nm, input logic [3:0] op,
                       input logic [127:0] a, input logic [127:0] b, input int sh,
                       input logic push, input logic [127:0] er,
                       input logic ec, input logic ev, input logic ei);
    exp_t e;
    int   k;
    logic ez, es;
    @(negedge clk);
    if (d == 0) begin
      iv8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; sh8 = 3'(sh);
    end else begin
      iv128 = 1'b1; op128 = op; a128 = a; b128 = b; sh128 = 7'(sh);
    end
    #1;
    if (d == 1 && !ir128) ir_low++;
    k = 0;
    while (((d == 0) ? !ir8 : !ir128) && k < 300) begin
      @(negedge clk); #1; k++;
    end
    if (k >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL %s_accept: in_ready got 0 expected 1 within budget", nm);
    end
    ez = (d == 0) ? (er[7:0] == 8'h00) : (er == '0);
    es = (d == 0) ? er[7] : er[127];
    e.nm = nm; e.r = er; e.f = {ec, ez, ev, es, ei};
    if (push) begin
      if (d == 0) q8.push_back(e); else q128.push_back(e);
    end
    @(posedge clk); #1;
    if (d == 0) iv8 = 1'b0; else iv128 = 1'b0;
  endtask

  task automatic wait_valid(input int d, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!((d == 0) ? ov8 : ov128) && n < budget);
  endtask

  logic [127:0] xa, xb, bp_exp;
  int n, cnt;

  initial begin
    rst8 = 1'b1; rst128 = 1'b1;
    iv8 = 0; op8 = 0; a8 = 0; b8 = 0; sh8 = 0; ordy8 = 1'b1;
    iv128 = 0; op128 = 0; a128 = 0; b128 = 0; sh128 = 0; ordy128 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_v("w8_rst_state", {120'b0, ov8, c8, z8, v8, s8, il8, 2'b0}, '0);
    chk_v("w8_rst_result", {120'b0, r8}, '0);
    chk_v("w128_rst_state", {122'b0, ov128, c128, z128, v128, s128, il128}, '0);
    @(negedge clk); rst8 = 1'b0; rst128 = 1'b0;
    @(posedge clk); #1;
    chk_v("w8_in_ready_after_rst", {127'b0, ir8}, 128'd1);
    chk_v("w128_in_ready_after_rst", {127'b0, ir128}, 128'd1);

    // ---- WIDTH=8 directed vectors ----
    issue(0, "w8_mul_10x11", 4'd2, 'h10, 'h11, 0, 1'b1, 'h10, 1'b1, 1'b1, 1'b0);
    wait_valid(0, 20, n);
    chk_v("w8_mul_latency", 128'(n), 128'd9);
    issue(0, "w8_slt_ff_01", 4'd12, 'hFF, 'h01, 0, 1'b1, 'h01, 1'b0, 1'b0, 1'b0);
    wait_valid(0, 5, n);
    chk_v("w8_alu_latency", 128'(n), 128'd1);
    issue(0, "w8_sge_ff_01",  4'd4,  'hFF, 'h01, 0, 1'b1, 'h00, 1'b0, 1'b0, 1'b0);
    issue(0, "w8_rol_81_1",   4'd11, 'h81, 'h00, 1, 1'b1, 'h03, 1'b0, 1'b0, 1'b0);
    issue(0, "w8_sll_81_1",   4'd8,  'h81, 'h00, 1, 1'b1, 'h02, 1'b1, 1'b0, 1'b0);
    issue(0, "w8_sra_80_3",   4'd13, 'h80, 'h00, 3, 1'b1, 'hF0, 1'b0, 1'b0, 1'b0);
    issue(0, "w8_srl_a5_0",   4'd0,  'hA5, 'h00, 0, 1'b1, 'hA5, 1'b0, 1'b0, 1'b0);
    issue(0, "w8_srl_03_1",   4'd0,  'h03, 'h00, 1, 1'b1, 'h01, 1'b1, 1'b0, 1'b0);
    issue(0, "w8_ror_01_1",   4'd6,  'h01, 'h00, 1, 1'b1, 'h80, 1'b0, 1'b0, 1'b0);
    issue(0, "w8_ror_5a_0",   4'd6,  'h5A, 'h00, 0, 1'b1, 'h5A, 1'b0, 1'b0, 1'b0);
    issue(0, "w8_min_80_7f",  4'd1,  'h80, 'h7F, 0, 1'b1, 'h7F, 1'b0, 1'b0, 1'b0);
    issue(0, "w8_and",        4'd3,  'hF0, 'h3C, 0, 1'b1, 'h30, 1'b0, 1'b0, 1'b0);
    issue(0, "w8_nand",       4'd9,  'hF0, 'h3C, 0, 1'b1, 'hCF, 1'b0, 1'b0, 1'b0);
    issue(0, "w8_xnor",       4'd5,  'hF0, 'h3C, 0, 1'b1, 'h33, 1'b0, 1'b0, 1'b0);
    issue(0, "w8_or",         4'd7,  'hF0, 'h3C, 0, 1'b1, 'hFC, 1'b0, 1'b0, 1'b0);
    issue(0, "w8_xor",        4'd10, 'hF0, 'h3C, 0, 1'b1, 'hCC, 1'b0, 1'b0, 1'b0);
    issue(0, "w8_illegal_14", 4'd14, 'h12, 'h34, 0, 1'b1, 'h00, 1'b0, 1'b0, 1'b1);
    issue(0, "w8_mul_0f_0f",  4'd2,  'h0F, 'h0F, 0, 1'b1, 'hE1, 1'b0, 1'b0, 1'b0);
    wait_valid(0, 20, n);
    chk_v("w8_mul2_latency", 128'(n), 128'd9);
    repeat (3) @(negedge clk);

    // ---- WIDTH=128: back-to-back XOR stream ----
    v128_cnt = 0; ir_low = 0;
    for (int i = 0; i < 4; i++) begin
      xa = {4{32'hDEADBEEF}} + 128'(i);
      xb = {32'h0, 32'h12345678, 32'h0, 32'(i * 3)} ^ {128{i[0]}};
      issue(1, $sformatf("w128_xor_%0d", i), 4'd10, xa, xb, 0, 1'b1, xa ^ xb, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk); #1;
    chk_v("w128_stream_valid_cycles", 128'(v128_cnt), 128'd4);
    chk_v("w128_stream_in_ready_low", 128'(ir_low), 128'd0);

    // ---- back-pressure: result held, in_ready low, in_valid ignored ----
    @(posedge clk); #1; ordy128 = 1'b0;
    xa = {64'hFFFF0000FFFF0000, 64'h0123456789ABCDEF};
    xb = {64'h00FF00FF00FF00FF, 64'hFEDCBA9876543210};
    bp_exp = xa ^ xb;
    issue(1, "w128_xor_bp", 4'd10, xa, xb, 0, 1'b1, bp_exp, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iv128 = 1'b1; op128 = 4'd3; a128 = '1; b128 = 128'(i);
      #1;
      chk_v("w128_bp_out_valid", {127'b0, ov128}, 128'd1);
      chk_v("w128_bp_result_stable", r128, bp_exp);
      chk_v("w128_bp_in_ready", {127'b0, ir128}, 128'd0);
    end
    iv128 = 1'b0;
    @(posedge clk); #1; ordy128 = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk_v("w128_bp_no_capture", {127'b0, ov128}, 128'd0);

    // ---- illegal opcode ----
    issue(1, "w128_illegal_15", 4'd15, {4{32'hA5A5A5A5}}, 128'd7, 0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    wait_valid(1, 5, n);
    chk_v("w128_illegal_latency", 128'(n), 128'd1);

    // ---- reset mid-MUL: no result may appear ----
    issue(1, "w128_mul_abort", 4'd2, {4{32'h1}}, 128'd3, 0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst128 = 1'b1;
    #1;
    chk_v("w128_abort_rst_state", {122'b0, ov128, c128, z128, v128, s128, il128}, '0);
    chk_v("w128_abort_rst_result", r128, '0);
    @(negedge clk); rst128 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (ov128) cnt++;
    end
    chk_v("w128_abort_no_out", 128'(cnt), 128'd0);
    issue(1, "w128_and_after_abort", 4'd3, {4{32'hF0F0F0F0}}, {4{32'hFF00FF00}}, 0, 1'b1,
          {4{32'hF000F000}}, 1'b0, 1'b0, 1'b0);
    wait_valid(1, 5, n);
    chk_v("w128_and_latency", 128'(n), 128'd1);

    repeat (3) @(negedge clk);
    chk_v("w8_scoreboard_drained", 128'(q8.size()), 128'd0);
    chk_v("w128_scoreboard_drained", 128'(q128.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

endmodule
